risc_v_id_ex_stage: RTL and testbench
=====================================

RISC_V_ID_EX_STAGE -- requirements
Module: risc_v_id_ex_stage

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, 32, datapath width; ADDR_WIDTH, 5, register address width; CTRL_WIDTH, 12, decoded control bundle width.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global freeze from downstream; retain register contents.
- flush  in  1  kill the instruction entering EX (taken branch or jump).
- id_valid  in  1  decode holds a real instruction.
- id_pc  in  DATA_WIDTH  PC of the decode instruction.
- id_rs1, id_rs2, id_rd  in  ADDR_WIDTH  decoded register addresses.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_ctrl  in  CTRL_WIDTH  decoded control bundle.
- rf_read_data1, rf_read_data2  in  DATA_WIDTH  combinational register-file read data.
- wb_reg_write  in  1  writeback write enable (same signal as the register-file write port).
- wb_write_addr  in  ADDR_WIDTH  writeback destination.
- wb_write_data  in  DATA_WIDTH  writeback data.
- load_use_stall  out  1  combinational; upstream (PC, IF/ID) SHALL hold when high.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_imm  out  DATA_WIDTH  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  ADDR_WIDTH  registered copies.
- ex_op1, ex_op2  out  DATA_WIDTH  registered operands.
- ex_ctrl  out  CTRL_WIDTH  registered control; forced to 0 on a bubble.

Function
REQ-003 Bypass SHALL apply: op1_in = wb_write_data when wb_reg_write, wb_write_addr == id_rs1 and id_rs1 != 0; otherwise rf_read_data1. op2_in SHALL be formed the same way from id_rs2 and rf_read_data2.
REQ-004 load_use_stall SHALL be asserted when id_valid, ex_valid and ex_ctrl[CTRL_MEM_READ] are all high, ex_rd != 0, and ex_rd equals id_rs1 or id_rs2; it SHALL be independent of hold and flush.
REQ-005 Each posedge SHALL apply exactly one action, in this priority order:
- rst: clear.
- flush: bubble.
- hold: retain.
- load_use_stall: bubble.
- otherwise: capture.
REQ-006 Capture SHALL load ex_valid = id_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, op1_in and op2_in; ex_ctrl SHALL take id_ctrl when id_valid is high and 0 when it is low.
REQ-007 A bubble SHALL set ex_valid = 0 and ex_ctrl = 0; the other fields are don't-care, and the implementation SHALL zero them.
REQ-008 On retain, all fields SHALL keep their values except the snoop: if ex_valid, wb_reg_write and wb_write_addr == ex_rs1 != 0, then ex_op1 <= wb_write_data; the same SHALL apply for ex_rs2 and ex_op2.
REQ-009 A write to x0 SHALL never be bypassed or snooped; x0 operands SHALL always be 0.
REQ-010 Latency SHALL be one cycle from ID inputs to EX outputs; there SHALL be no combinational path from ID inputs to EX outputs.
REQ-011 When flush and load_use_stall are high together, flush SHALL win and the slot becomes a bubble; upstream holding is the hazard unit's concern.

Reset
REQ-012 While rst is high at a posedge, all outputs SHALL be 0 on the following cycle, including ex_valid, ex_ctrl, ex_op1 and ex_op2.
REQ-013 Reset asserted mid-hold or mid-stall SHALL discard the in-flight instruction; there is no recovery of it.
REQ-014 load_use_stall SHALL be 0 in the cycle after reset, because ex_valid is 0.

Structure
REQ-015 A shared package risc_v_pkg SHALL hold the following; the control decoder SHALL use the same package:
- CTRL_WIDTH.
- Bit indices CTRL_REG_WRITE=0, CTRL_MEM_READ=1, CTRL_MEM_WRITE=2, CTRL_BRANCH=3, CTRL_JUMP=4, CTRL_ALU_SRC=5, CTRL_WB_SEL=7:6, CTRL_ALU_OP=11:8.
REQ-016 One sub-module, risc_v_hazard_detect, SHALL hold the combinational load_use_stall logic of REQ-004; the bypass and snoop logic SHALL be inline.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Capture: id_valid=1, rs1=3, rs2=4, rf data 0x11/0x22, no writeback -> next cycle ex_op1=0x11, ex_op2=0x22, ex_valid=1.
- Bypass: rs1=5 with rf data 0x0; wb_reg_write=1, addr 5, data 0xDEADBEEF in the same cycle -> ex_op1=0xDEADBEEF; repeat with addr 0 -> ex_op1 = rf data, no bypass.
- Load-use: EX holds a load with rd=7; ID has rs2=7 -> load_use_stall=1; next cycle ex_valid=0, ex_ctrl=0; after the stall drops, the instruction is captured.
- Hold snoop: ex_valid=1, ex_rs1=9, hold=1; writeback addr 9, data 0x1234 -> ex_op1=0x1234 while all other fields stay unchanged.
- Priority: flush=1 with hold=1 -> bubble; flush=1 with load_use_stall=1 -> bubble.
- Reset: rst=1 mid-hold with ex_valid=1 -> all outputs 0 next cycle, load_use_stall=0.

Source files
------------

// File: rtl/risc_v_pkg.sv
// Shared decode definitions for the pipeline: control-bundle width and bit positions.
// Both the decoder and the ID/EX stage use these, so the two always agree on the layout.
package risc_v_pkg;

  localparam int CTRL_WIDTH     = 12;

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_JUMP      = 4;
  localparam int CTRL_ALU_SRC   = 5;
  localparam int CTRL_WB_SEL_LO = 6;
  localparam int CTRL_WB_SEL_HI = 7;
  localparam int CTRL_ALU_OP_LO = 8;
  localparam int CTRL_ALU_OP_HI = 11;

endpackage

// File: rtl/risc_v_hazard_detect.sv
// Load-use hazard detect: purely combinational, zero latency.
// Upstream must freeze while load_use_stall is high; hold and flush do not affect it.
module risc_v_hazard_detect #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  load_use_stall
);

  // A load targeting x0 produces nothing a consumer could wait on.
  always_comb begin
    load_use_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/risc_v_id_ex_stage.sv
// ID/EX pipeline register with writeback bypass and retain-time snoop; one-cycle latency.
// Priority per edge is rst > flush > hold > load-use bubble > capture; hold freezes the slot.
module risc_v_id_ex_stage
  import risc_v_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = risc_v_pkg::CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] wb_write_addr,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic                  load_use_stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [ADDR_WIDTH-1:0] ex_rs1,
  output logic [ADDR_WIDTH-1:0] ex_rs2,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0] ex_op1,
  output logic [DATA_WIDTH-1:0] ex_op2,
  output logic [CTRL_WIDTH-1:0] ex_ctrl
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [CTRL_WIDTH-1:0] ctrl;
  } ex_slot_t;

  ex_slot_t              ex_q, ex_d;
  logic [DATA_WIDTH-1:0] op1_in, op2_in;

  risc_v_hazard_detect #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_hazard (
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_valid      (ex_q.valid),
    .ex_mem_read   (ex_q.ctrl[CTRL_MEM_READ]),
    .ex_rd         (ex_q.rd),
    .load_use_stall(load_use_stall)
  );

  // The register file is read before this cycle's writeback lands, so forward it here.
  always_comb begin
    op1_in = rf_read_data1;
    op2_in = rf_read_data2;
    if (wb_reg_write && (wb_write_addr == id_rs1) && (id_rs1 != '0)) op1_in = wb_write_data;
    if (wb_reg_write && (wb_write_addr == id_rs2) && (id_rs2 != '0)) op2_in = wb_write_data;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      // A frozen slot would otherwise miss a writeback that retires while it waits.
      if (ex_q.valid && wb_reg_write && (wb_write_addr == ex_q.rs1) && (ex_q.rs1 != '0))
        ex_d.op1 = wb_write_data;
      if (ex_q.valid && wb_reg_write && (wb_write_addr == ex_q.rs2) && (ex_q.rs2 != '0))
        ex_d.op2 = wb_write_data;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid = id_valid;
      ex_d.pc    = id_pc;
      ex_d.imm   = id_imm;
      ex_d.rs1   = id_rs1;
      ex_d.rs2   = id_rs2;
      ex_d.rd    = id_rd;
      ex_d.op1   = op1_in;
      ex_d.op2   = op2_in;
      ex_d.ctrl  = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid = ex_q.valid;
  assign ex_pc    = ex_q.pc;
  assign ex_imm   = ex_q.imm;
  assign ex_rs1   = ex_q.rs1;
  assign ex_rs2   = ex_q.rs2;
  assign ex_rd    = ex_q.rd;
  assign ex_op1   = ex_q.op1;
  assign ex_op2   = ex_q.op2;
  assign ex_ctrl  = ex_q.ctrl;

endmodule

// File: tb/tb_risc_v_id_ex_stage.sv
// Directed table-driven bench for the ID/EX stage, followed by a multi-cycle hold sequence.
module tb_risc_v_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid;
  logic [31:0] id_pc, id_imm, rf_read_data1, rf_read_data2, wb_write_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_write_addr;
  logic [11:0] id_ctrl;
  logic        wb_reg_write;
  logic        load_use_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [11:0] ex_ctrl;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  always #5 clk = ~clk;

  risc_v_id_ex_stage #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .CTRL_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_ctrl(ex_ctrl)
  );

  typedef struct packed {
    logic        rst, hold, flush, idv;
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] ctrl;
    logic [31:0] rf1, rf2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        e_stall, e_valid;
    logic [31:0] e_pc, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_op1, e_op2;
    logic [11:0] e_ctrl;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic r, input logic h, input logic f, input logic v,
    input logic [31:0] pc, input logic [31:0] imm,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [11:0] ctrl,
    input logic [31:0] rf1, input logic [31:0] rf2,
    input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
    input logic es, input logic ev, input logic [31:0] epc, input logic [31:0] eimm,
    input logic [4:0] ers1, input logic [4:0] ers2, input logic [4:0] erd,
    input logic [31:0] eop1, input logic [31:0] eop2, input logic [11:0] ectrl);
    vec_t t;
    t.rst = r; t.hold = h; t.flush = f; t.idv = v; t.pc = pc; t.imm = imm;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.ctrl = ctrl; t.rf1 = rf1; t.rf2 = rf2;
    t.wbe = wbe; t.wba = wba; t.wbd = wbd; t.e_stall = es; t.e_valid = ev;
    t.e_pc = epc; t.e_imm = eimm; t.e_rs1 = ers1; t.e_rs2 = ers2; t.e_rd = erd;
    t.e_op1 = eop1; t.e_op2 = eop2; t.e_ctrl = ectrl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h, expected %h", cur, name, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t t);
    chk("ex_valid", 32'(ex_valid), 32'(t.e_valid));
    chk("ex_pc",    ex_pc,         t.e_pc);
    chk("ex_imm",   ex_imm,        t.e_imm);
    chk("ex_rs1",   32'(ex_rs1),   32'(t.e_rs1));
    chk("ex_rs2",   32'(ex_rs2),   32'(t.e_rs2));
    chk("ex_rd",    32'(ex_rd),    32'(t.e_rd));
    chk("ex_op1",   ex_op1,        t.e_op1);
    chk("ex_op2",   ex_op2,        t.e_op2);
    chk("ex_ctrl",  32'(ex_ctrl),  32'(t.e_ctrl));
  endtask

  initial begin
    // Control encodings: 12'h201 = ALU op with reg write, 12'h003 = load (mem read + reg write).
    //            rst h  f  v  pc          imm         rs1    rs2    rd     ctrl     rf1           rf2           wbe wba    wbd             stl ev  e_pc        e_imm       ers1   ers2   erd    e_op1         e_op2         e_ctrl
    vecs[0]  = mk(1, 0, 0, 1, 32'h200, 32'h5,  5'd3,  5'd4,  5'd5,  12'h003, 32'h1,  32'h2,  1, 5'd3,  32'h9,        0, 0, 32'h0,   32'h0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,    12'h000);
    vecs[1]  = mk(0, 0, 0, 1, 32'h100, 32'h10, 5'd3,  5'd4,  5'd1,  12'h201, 32'h11, 32'h22, 0, 5'd0,  32'h0,        0, 1, 32'h100, 32'h10, 5'd3,  5'd4,  5'd1,  32'h11,       32'h22,   12'h201);
    vecs[2]  = mk(0, 0, 0, 1, 32'h104, 32'h20, 5'd5,  5'd6,  5'd2,  12'h201, 32'h0,  32'h66, 1, 5'd5,  32'hDEADBEEF, 0, 1, 32'h104, 32'h20, 5'd5,  5'd6,  5'd2,  32'hDEADBEEF, 32'h66,   12'h201);
    vecs[3]  = mk(0, 0, 0, 1, 32'h108, 32'h30, 5'd5,  5'd0,  5'd3,  12'h201, 32'h55, 32'h0,  1, 5'd0,  32'hCAFEF00D, 0, 1, 32'h108, 32'h30, 5'd5,  5'd0,  5'd3,  32'h55,       32'h0,    12'h201);
    vecs[4]  = mk(0, 0, 0, 0, 32'h10C, 32'h40, 5'd1,  5'd2,  5'd4,  12'h201, 32'h77, 32'h88, 0, 5'd0,  32'h0,        0, 0, 32'h10C, 32'h40, 5'd1,  5'd2,  5'd4,  32'h77,       32'h88,   12'h000);
    vecs[5]  = mk(0, 0, 0, 1, 32'h110, 32'h4,  5'd1,  5'd2,  5'd7,  12'h003, 32'hA,  32'hB,  0, 5'd0,  32'h0,        0, 1, 32'h110, 32'h4,  5'd1,  5'd2,  5'd7,  32'hA,        32'hB,    12'h003);
    vecs[6]  = mk(0, 0, 0, 1, 32'h114, 32'h0,  5'd8,  5'd7,  5'd9,  12'h201, 32'h1,  32'h2,  0, 5'd0,  32'h0,        1, 0, 32'h0,   32'h0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,    12'h000);
    vecs[7]  = mk(0, 0, 0, 1, 32'h114, 32'h0,  5'd8,  5'd7,  5'd9,  12'h201, 32'h1,  32'h2,  1, 5'd7,  32'h5A5A,     0, 1, 32'h114, 32'h0,  5'd8,  5'd7,  5'd9,  32'h1,        32'h5A5A, 12'h201);
    vecs[8]  = mk(0, 0, 0, 1, 32'h118, 32'h8,  5'd9,  5'd10, 5'd11, 12'h201, 32'h99, 32'hAA, 0, 5'd0,  32'h0,        0, 1, 32'h118, 32'h8,  5'd9,  5'd10, 5'd11, 32'h99,       32'hAA,   12'h201);
    vecs[9]  = mk(0, 1, 0, 1, 32'h11C, 32'h1,  5'd1,  5'd2,  5'd3,  12'h003, 32'h5,  32'h6,  1, 5'd9,  32'h1234,     0, 1, 32'h118, 32'h8,  5'd9,  5'd10, 5'd11, 32'h1234,     32'hAA,   12'h201);
    vecs[10] = mk(0, 1, 0, 1, 32'h11C, 32'h1,  5'd1,  5'd2,  5'd3,  12'h003, 32'h5,  32'h6,  1, 5'd10, 32'hBBBB,     0, 1, 32'h118, 32'h8,  5'd9,  5'd10, 5'd11, 32'h1234,     32'hBBBB, 12'h201);
    vecs[11] = mk(0, 1, 1, 1, 32'h11C, 32'h1,  5'd1,  5'd2,  5'd3,  12'h003, 32'h5,  32'h6,  1, 5'd9,  32'h7777,     0, 0, 32'h0,   32'h0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,    12'h000);
    vecs[12] = mk(0, 0, 0, 1, 32'h120, 32'hC,  5'd2,  5'd3,  5'd12, 12'h003, 32'h1,  32'h2,  0, 5'd0,  32'h0,        0, 1, 32'h120, 32'hC,  5'd2,  5'd3,  5'd12, 32'h1,        32'h2,    12'h003);
    vecs[13] = mk(0, 0, 1, 1, 32'h124, 32'h0,  5'd12, 5'd0,  5'd1,  12'h201, 32'h3,  32'h0,  0, 5'd0,  32'h0,        1, 0, 32'h0,   32'h0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,    12'h000);
    vecs[14] = mk(0, 0, 0, 1, 32'h128, 32'h10, 5'd4,  5'd5,  5'd13, 12'h003, 32'h3,  32'h4,  0, 5'd0,  32'h0,        0, 1, 32'h128, 32'h10, 5'd4,  5'd5,  5'd13, 32'h3,        32'h4,    12'h003);
    vecs[15] = mk(0, 1, 0, 1, 32'h12C, 32'h0,  5'd13, 5'd1,  5'd2,  12'h201, 32'h9,  32'h9,  0, 5'd0,  32'h0,        1, 1, 32'h128, 32'h10, 5'd4,  5'd5,  5'd13, 32'h3,        32'h4,    12'h003);
    vecs[16] = mk(1, 1, 0, 1, 32'h12C, 32'h0,  5'd13, 5'd1,  5'd2,  12'h201, 32'h9,  32'h9,  0, 5'd0,  32'h0,        1, 0, 32'h0,   32'h0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,    12'h000);
    vecs[17] = mk(0, 0, 0, 1, 32'h130, 32'h0,  5'd13, 5'd1,  5'd14, 12'h201, 32'h31, 32'h32, 0, 5'd0,  32'h0,        0, 1, 32'h130, 32'h0,  5'd13, 5'd1,  5'd14, 32'h31,       32'h32,   12'h201);
    vecs[18] = mk(0, 0, 0, 1, 32'h134, 32'h0,  5'd1,  5'd2,  5'd0,  12'h003, 32'h5,  32'h6,  0, 5'd0,  32'h0,        0, 1, 32'h134, 32'h0,  5'd1,  5'd2,  5'd0,  32'h5,        32'h6,    12'h003);
    vecs[19] = mk(0, 0, 0, 1, 32'h138, 32'h0,  5'd0,  5'd0,  5'd1,  12'h201, 32'h0,  32'h0,  0, 5'd0,  32'h0,        0, 1, 32'h138, 32'h0,  5'd0,  5'd0,  5'd1,  32'h0,        32'h0,    12'h201);

    rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_pc = '0; id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_ctrl = '0;
    rf_read_data1 = '0; rf_read_data2 = '0;
    wb_reg_write = 1'b0; wb_write_addr = '0; wb_write_data = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      cur = i;
      @(negedge clk);
      rst = vecs[i].rst; hold = vecs[i].hold; flush = vecs[i].flush; id_valid = vecs[i].idv;
      id_pc = vecs[i].pc; id_imm = vecs[i].imm; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_rd = vecs[i].rd; id_ctrl = vecs[i].ctrl;
      rf_read_data1 = vecs[i].rf1; rf_read_data2 = vecs[i].rf2;
      wb_reg_write = vecs[i].wbe; wb_write_addr = vecs[i].wba; wb_write_data = vecs[i].wbd;
      #1;
      chk("load_use_stall", 32'(load_use_stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check_outputs(vecs[i]);
    end

    // Multi-cycle hold on the x0-sourced instruction: writebacks to x0 must never be snooped.
    for (int c = 0; c < 3; c++) begin
      cur = NV + c;
      @(negedge clk);
      rst = 1'b0; hold = 1'b1; flush = 1'b0; id_valid = 1'b1;
      id_pc = 32'h13C; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_ctrl = 12'h201;
      wb_reg_write = 1'b1; wb_write_addr = 5'd0; wb_write_data = 32'hFFFF_FFFF;
      #1;
      chk("hold_stall", 32'(load_use_stall), 32'd0);
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(ex_valid), 32'd1);
      chk("hold_pc", ex_pc, 32'h138);
      chk("hold_op1_x0", ex_op1, 32'h0);
      chk("hold_op2_x0", ex_op2, 32'h0);
    end

    // Releasing hold captures the waiting instruction with the x0 write not forwarded.
    cur = NV + 3;
    @(negedge clk);
    hold = 1'b0; wb_write_addr = 5'd1; wb_write_data = 32'h4242;
    rf_read_data1 = 32'h1; rf_read_data2 = 32'h2;
    @(posedge clk);
    #1;
    chk("release_pc", ex_pc, 32'h13C);
    chk("release_op1", ex_op1, 32'h4242);
    chk("release_op2", ex_op2, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
